// File: rtl/sample_store.sv
// sample_store
//   Training-sample buffer feeding the neuron datapath. Samples (x1, x2, t)
//   are written in while in LOAD, then replayed one per init/next handshake
//   while in SERVE, with EOF marking the end of each epoch.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   clear     empty the store and return to LOAD
//   wr_en     write request, accepted only when wr_ready=1
//   wr_x1     sample feature 1 (XW bits, two's complement)
//   wr_x2     sample feature 2 (XW bits, two's complement)
//   wr_t      sample target (TW bits, 2'b01=+1, 2'b11=-1)
//   wr_ready  store is in LOAD and not full
//   init      start / restart an epoch
//   next      advance to the next sample
//   x1,x2,t   current sample, registered
//   valid     x1/x2/t hold a stored sample
//   EOF       epoch exhausted, or store empty
//   count     number of stored samples (AW+1 bits)

module sample_store #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int XW    = 7,
  parameter int TW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x1,
  input  logic [XW-1:0] wr_x2,
  input  logic [TW-1:0] wr_t,
  output logic          wr_ready,
  input  logic          init,
  input  logic          next,
  output logic [XW-1:0] x1,
  output logic [XW-1:0] x2,
  output logic [TW-1:0] t,
  output logic          valid,
  output logic          EOF,
  output logic [AW:0]   count
);

  localparam int SW = 2*XW + TW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {LOAD, SERVE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   rd_ptr;

  logic          do_write;
  logic          do_rewind;
  logic          do_advance;
  logic          do_finish;
  logic          store_empty;

  assign store_empty = (count == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: clear always wins; an epoch can only start once
  // something has been loaded. SERVE is left only through clear or reset.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LOAD;
    end else if (state == LOAD && init && !store_empty) begin
      state_nxt = SERVE;
    end
  end

  // Output / control decode. Priority is clear > init > next > wr_en, so
  // each lower-priority action is masked by everything above it.
  always_comb begin
    wr_ready   = (state == LOAD) && (count < DEPTH_C);
    do_rewind  = !clear && init && !store_empty;
    do_write   = !clear && !init && (state == LOAD) && wr_en && wr_ready;
    do_advance = !clear && !init && (state == SERVE) && next && !EOF &&
                 (rd_ptr < count);
    do_finish  = !clear && !init && (state == SERVE) && next && !EOF &&
                 (rd_ptr == count);
  end

  // Sample array. Contents are deliberately not reset; count and the
  // pointers define which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {wr_x1, wr_x2, wr_t};
    end
  end

  // Pointers, count and the registered sample outputs. rd_ptr always points
  // at the slot that the next 'next' will present, so a rewind shows slot 0
  // and leaves rd_ptr at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      x1     <= '0;
      x2     <= '0;
      t      <= '0;
      valid  <= 1'b0;
      EOF    <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      x1     <= '0;
      x2     <= '0;
      t      <= '0;
      valid  <= 1'b0;
      EOF    <= 1'b1;
    end else if (do_rewind) begin
      {x1, x2, t} <= mem[0];
      rd_ptr      <= (AW+1)'(1);
      valid       <= 1'b1;
      EOF         <= 1'b0;
    end else if (do_advance) begin
      {x1, x2, t} <= mem[rd_ptr[AW-1:0]];
      rd_ptr      <= rd_ptr + (AW+1)'(1);
    end else if (do_finish) begin
      EOF <= 1'b1;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_sample_store.sv
module tb_sample_store;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       wr_en;
  logic [6:0] wr_x1;
  logic [6:0] wr_x2;
  logic [1:0] wr_t;
  logic       wr_ready;
  logic       init;
  logic       next;
  logic [6:0] x1;
  logic [6:0] x2;
  logic [1:0] t;
  logic       valid;
  logic       EOF;
  logic [6:0] count;

  int errors = 0;
  int checks = 0;

  // Expected samples for the three-sample scenario: (3,-2,+1) (-5,4,-1) (1,1,+1)
  logic [15:0] small_set [3];

  sample_store dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
    .wr_ready(wr_ready), .init(init), .next(next),
    .x1(x1), .x2(x2), .t(t), .valid(valid), .EOF(EOF), .count(count)
  );

  always #5 clk = ~clk;

  // All stimulus tasks start and end at a falling edge: inputs change there,
  // the DUT captures on the rising edge, and results are read at the next
  // falling edge.
  task automatic write_sample(input logic [6:0] a, input logic [6:0] b, input logic [1:0] c);
    wr_en = 1'b1; wr_x1 = a; wr_x2 = b; wr_t = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  function automatic logic [15:0] big_sample(input int i);
    logic [6:0] a;
    a = 7'(i);
    return {a, ~a, (i % 2 == 1) ? 2'b01 : 2'b11};
  endfunction

  task automatic test_reset();
    rst = 1'b1; clear = 0; wr_en = 0; init = 0; next = 0;
    wr_x1 = 0; wr_x2 = 0; wr_t = 0;
    @(negedge clk);
    checks++;
    if ({x1, x2, t, valid, EOF, count, wr_ready} !== {7'd0, 7'd0, 2'b00, 1'b0, 1'b1, 7'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state: got x1=%h x2=%h t=%b v=%b eof=%b cnt=%0d rdy=%b expected 0 0 00 0 1 0 1",
               x1, x2, t, valid, EOF, count, wr_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_replay();
    for (int i = 0; i < 3; i++)
      write_sample(small_set[i][15:9], small_set[i][8:2], small_set[i][1:0]);
    checks++;
    if ({count, EOF, valid} !== {7'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL load_three: got cnt=%0d eof=%b v=%b expected 3 1 0", count, EOF, valid);
    end
    pulse_init();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) pulse_next();
      checks++;
      if ({x1, x2, t, valid, EOF} !== {small_set[i], 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL replay_%0d: got %h %h %b v=%b eof=%b expected %h v=1 eof=0",
                 i, x1, x2, t, valid, EOF, small_set[i]);
      end
    end
    pulse_next();
    checks++;
    if ({x1, x2, t, valid, EOF, count} !== {small_set[2], 1'b1, 1'b1, 7'd3}) begin
      errors++;
      $display("[TB] FAIL replay_eof: got %h %h %b v=%b eof=%b cnt=%0d expected %h v=1 eof=1 cnt=3",
               x1, x2, t, valid, EOF, count, small_set[2]);
    end
  endtask

  task automatic test_second_epoch();
    int bad = 0;
    pulse_init();
    checks++;
    if ({x1, x2, t, EOF} !== {small_set[0], 1'b0}) begin
      errors++;
      $display("[TB] FAIL rewind: got %h %h %b eof=%b expected %h eof=0", x1, x2, t, EOF, small_set[0]);
    end
    for (int i = 1; i < 3; i++) begin
      pulse_next();
      if ({x1, x2, t, EOF} !== {small_set[i], 1'b0}) bad++;
    end
    pulse_next();
    if (EOF !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL second_epoch: got %0d bad steps expected 0", bad);
    end
  endtask

  task automatic test_init_next_together();
    pulse_init();
    pulse_next();
    init = 1'b1; next = 1'b1;
    @(negedge clk);
    init = 1'b0; next = 1'b0;
    checks++;
    if ({x1, x2, t, EOF} !== {small_set[0], 1'b0}) begin
      errors++;
      $display("[TB] FAIL init_and_next: got %h %h %b eof=%b expected %h eof=0", x1, x2, t, EOF, small_set[0]);
    end
    pulse_next();
    checks++;
    if ({x1, x2, t} !== small_set[1]) begin
      errors++;
      $display("[TB] FAIL rdptr_after_init: got %h %h %b expected %h", x1, x2, t, small_set[1]);
    end
    pulse_next();
    pulse_next();
    pulse_next();
    checks++;
    if ({x1, x2, t, valid, EOF} !== {small_set[2], 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL next_at_eof: got %h %h %b v=%b eof=%b expected %h v=1 eof=1",
               x1, x2, t, valid, EOF, small_set[2]);
    end
  endtask

  task automatic test_clear_and_empty();
    pulse_clear();
    checks++;
    if ({x1, x2, t, valid, EOF, count, wr_ready} !== {16'd0, 1'b0, 1'b1, 7'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clear_state: got %h %h %b v=%b eof=%b cnt=%0d rdy=%b expected 0 v=0 eof=1 cnt=0 rdy=1",
               x1, x2, t, valid, EOF, count, wr_ready);
    end
    pulse_init();
    checks++;
    if ({valid, EOF, wr_ready} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL init_empty: got v=%b eof=%b rdy=%b expected v=0 eof=1 rdy=1", valid, EOF, wr_ready);
    end
    write_sample(7'd9, 7'd9, 2'b01);
    clear = 1'b1; wr_en = 1'b1; wr_x1 = 7'd10;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    checks++;
    if (count !== 7'd0) begin
      errors++;
      $display("[TB] FAIL clear_with_write: got cnt=%0d expected 0", count);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] s;
      s = big_sample(i);
      write_sample(s[15:9], s[8:2], s[1:0]);
    end
    checks++;
    if ({count, wr_ready} !== {7'd64, 1'b0}) begin
      errors++;
      $display("[TB] FAIL full: got cnt=%0d rdy=%b expected 64 0", count, wr_ready);
    end
    write_sample(7'h55, 7'h2A, 2'b01);
    checks++;
    if (count !== 7'd64) begin
      errors++;
      $display("[TB] FAIL drop_65th: got cnt=%0d expected 64", count);
    end
    pulse_init();
    for (int i = 0; i < 64; i++) begin
      if (i > 0) pulse_next();
      if ({x1, x2, t, EOF} !== {big_sample(i), 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL full_replay: got %0d bad slots expected 0", bad);
    end
    pulse_next();
    checks++;
    if ({EOF, x1, x2, t} !== {1'b1, big_sample(63)}) begin
      errors++;
      $display("[TB] FAIL full_eof: got eof=%b %h %h %b expected eof=1 %h", EOF, x1, x2, t, big_sample(63));
    end
  endtask

  task automatic test_async_reset();
    pulse_init();
    pulse_next();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({x1, x2, t, valid, EOF, count, wr_ready} !== {16'd0, 1'b0, 1'b1, 7'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h %h %b v=%b eof=%b cnt=%0d rdy=%b expected 0 v=0 eof=1 cnt=0 rdy=1",
               x1, x2, t, valid, EOF, count, wr_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write_sample(7'h7F, 7'h01, 2'b11);
    pulse_init();
    checks++;
    if ({count, x1, x2, t, valid, EOF} !== {7'd1, 7'h7F, 7'h01, 2'b11, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_after_reset: got cnt=%0d %h %h %b v=%b eof=%b expected 1 7f 01 11 v=1 eof=0",
               count, x1, x2, t, valid, EOF);
    end
  endtask

  initial begin
    small_set[0] = {7'd3,  7'h7E, 2'b01};
    small_set[1] = {7'h7B, 7'd4,  2'b11};
    small_set[2] = {7'd1,  7'd1,  2'b01};
    test_reset();
    test_basic_replay();
    test_second_epoch();
    test_init_next_together();
    test_clear_and_empty();
    test_full();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
